key_press_conditioner: RTL and testbench

//   Upstream input stage for the slot-machine top level: turns raw, bouncing, active-low board

---
 rtl/key_cond_pkg.sv | 11 +
 rtl/key_debounce_ch.sv | 96 +++++++++
 rtl/key_press_conditioner.sv | 31 +++
 tb/tb_key_press_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared state encoding, timing defaults and counter sizing for the key conditioner.
package key_cond_pkg;
  typedef enum logic [1:0] {UP, CHK_DN, DOWN, CHK_UP} key_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES = 50_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_LONG_CYCLES = 10;
  function automatic int cnt_width(input int deb, input int lng);
    return $clog2((deb > lng ? deb : lng) + 1);
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-flop synchroniser, debounce FSM, hold timer and pulse registers.
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press
);
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_bad_params
    $error("key_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
  end
  logic [1:0] sync;
  logic s;
  key_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, hold, hold_n;
  logic level_n, press_n, rel_n, long_n;
  assign s = ~sync[1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync <= 2'b11;
      state <= UP;
      cnt <= '0;
      hold <= '0;
      level <= 1'b0;
      press <= 1'b0;
      released <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync <= {sync[0], key_n};
      state <= state_n;
      cnt <= cnt_n;
      hold <= hold_n;
      level <= level_n;
      press <= press_n;
      released <= rel_n;
      long_press <= long_n;
    end
  // The hold timer keeps running through a release bounce so long_press timing is unaffected.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hold_n = hold;
    level_n = level;
    press_n = 1'b0;
    rel_n = 1'b0;
    long_n = 1'b0;
    if ((state == DOWN || state == CHK_UP) && hold != HOLD_MAX) begin
      hold_n = hold + CNT_ONE;
      long_n = hold == HOLD_LAST;
    end
    case (state)
      UP: if (s) begin
        state_n = CHK_DN;
        cnt_n = CNT_ONE;
      end
      CHK_DN: if (!s) begin
        state_n = UP;
        cnt_n = '0;
      end else if (cnt == DEB_LAST) begin
        state_n = DOWN;
        cnt_n = '0;
        hold_n = '0;
        level_n = 1'b1;
        press_n = 1'b1;
      end else cnt_n = cnt + CNT_ONE;
      DOWN: if (!s) begin
        state_n = CHK_UP;
        cnt_n = CNT_ONE;
      end
      CHK_UP: if (s) begin
        state_n = DOWN;
        cnt_n = '0;
      end else if (cnt == DEB_LAST) begin
        state_n = UP;
        cnt_n = '0;
        hold_n = '0;
        level_n = 1'b0;
        rel_n = 1'b1;
        long_n = 1'b0;
      end else cnt_n = cnt + CNT_ONE;
      default: state_n = UP;
    endcase
  end
endmodule

// File: rtl/key_press_conditioner.sv
// key_press_conditioner: NUM_KEYS independent debounced key channels producing level, press, release and long-press.
module key_press_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] released,
  output logic [NUM_KEYS-1:0] long_press
);
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .key_n(key_n[k]),
      .level(level[k]),
      .press(press[k]),
      .released(released[k]),
      .long_press(long_press[k])
    );
  end
endmodule

// File: tb/tb_key_press_conditioner.sv
// tb_key_press_conditioner: vector table, directed corner sequences and random stimulus against a run-length reference model.
module tb_key_press_conditioner;
  import key_cond_pkg::*;
  localparam int NK = 2;
  localparam int DEB = SIM_DEBOUNCE_CYCLES;
  localparam int LONG = SIM_LONG_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] level, press, released, long_press;
  int checks = 0, errors = 0, cyc = 0;
  int press_cnt[NK], press_at[NK], rel_cnt[NK], rel_at[NK], long_cnt[NK], long_at[NK];

  key_press_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .level(level),
    .press(press),
    .released(released),
    .long_press(long_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: a key's debounced level flips once DEB consecutive synchronised samples disagree with it.
  typedef struct {logic d1, d2, lvl, prs, rel, lng; int run, age;} mst_t;
  mst_t m[NK];

  function automatic mst_t step(input mst_t s, input logic kn);
    mst_t n = s;
    logic x = s.d2;
    n.d2 = s.d1;
    n.d1 = ~kn;
    n.prs = 1'b0;
    n.rel = 1'b0;
    n.lng = 1'b0;
    n.run = (x != s.lvl) ? s.run + 1 : 0;
    if (n.run == DEB) begin
      n.lvl = ~s.lvl;
      n.prs = n.lvl;
      n.rel = s.lvl;
      n.run = 0;
      n.age = 0;
    end else if (s.lvl && s.age < LONG) begin
      n.age = s.age + 1;
      n.lng = n.age == LONG;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NK; i++) m[i] <= '{default: 0};
    else for (int i = 0; i < NK; i++) m[i] <= step(m[i], key_n[i]);

  function automatic logic [4*NK-1:0] exp_vec();
    logic [NK-1:0] lv, pr, rl, lg;
    for (int i = 0; i < NK; i++) begin
      lv[i] = m[i].lvl;
      pr[i] = m[i].prs;
      rl[i] = m[i].rel;
      lg[i] = m[i].lng;
    end
    return {lv, pr, rl, lg};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; press_at[i] = -1;
      rel_cnt[i] = 0; rel_at[i] = -1;
      long_cnt[i] = 0; long_at[i] = -1;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("model", 64'({level, press, released, long_press}), 64'(exp_vec()));
      for (int i = 0; i < NK; i++) begin
        if (press[i]) begin press_cnt[i]++; press_at[i] = cyc; end
        if (released[i]) begin rel_cnt[i]++; rel_at[i] = cyc; end
        if (long_press[i]) begin long_cnt[i]++; long_at[i] = cyc; end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    clear_mon();
  endtask

  typedef struct {logic [NK-1:0] kn; logic [4*NK-1:0] exp;} vec_t;
  vec_t tbl[24];

  initial begin
    int b, b2;
    for (int e = 1; e <= 24; e++) begin
      logic lv, pr, rl;
      lv = e >= 6 && e <= 13;
      pr = e == 6;
      rl = e == 14;
      tbl[e-1].kn = (e <= 8 || (e >= 15 && e <= 17)) ? 2'b10 : 2'b11;
      tbl[e-1].exp = {1'b0, lv, 1'b0, pr, 1'b0, rl, 2'b00};
    end
    clear_mon();
    key_n = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("reset_outputs", 64'({level, press, released, long_press}), 64'(0));
    // clean press, short hold release, then a 3-cycle glitch
    for (int i = 0; i < 24; i++) begin
      key_n = tbl[i].kn;
      tick();
      check($sformatf("vec%0d", i + 1), 64'({level, press, released, long_press}), 64'(tbl[i].exp));
    end
    // long hold then clean release
    do_reset();
    key_n = 2'b10;
    b = cyc;
    tick(26);
    key_n = 2'b11;
    b2 = cyc;
    tick(12);
    check("t3_press_cnt", 64'(press_cnt[0]), 64'(1));
    check("t3_press_at", 64'(press_at[0]), 64'(b + 6));
    check("t3_long_cnt", 64'(long_cnt[0]), 64'(1));
    check("t3_long_at", 64'(long_at[0]), 64'(b + 16));
    check("t3_rel_cnt", 64'(rel_cnt[0]), 64'(1));
    check("t3_rel_at", 64'(rel_at[0]), 64'(b2 + 6));
    check("t3_key1_quiet", 64'(press_cnt[1] + rel_cnt[1] + long_cnt[1]), 64'(0));
    // release bounce during hold
    do_reset();
    key_n = 2'b10;
    b = cyc;
    tick(10);
    key_n = 2'b11;
    tick(2);
    key_n = 2'b10;
    tick(10);
    check("t4_no_release", 64'(rel_cnt[0]), 64'(0));
    check("t4_long_cnt", 64'(long_cnt[0]), 64'(1));
    check("t4_long_at", 64'(long_at[0]), 64'(b + 16));
    check("t4_level", 64'(level[0]), 64'(1));
    // both keys together
    do_reset();
    key_n = 2'b00;
    b = cyc;
    tick(8);
    check("t5_press0_at", 64'(press_at[0]), 64'(b + 6));
    check("t5_press1_at", 64'(press_at[1]), 64'(b + 6));
    check("t5_press_cnt", 64'(press_cnt[0] + press_cnt[1]), 64'(2));
    // reset during hold with key kept down
    do_reset();
    key_n = 2'b10;
    tick(9);
    rst = 1'b0;
    #1;
    check("t6_async_clear", 64'({level, press, released, long_press}), 64'(0));
    tick(2);
    rst = 1'b1;
    clear_mon();
    b = cyc;
    tick(8);
    check("t6_press_cnt", 64'(press_cnt[0]), 64'(1));
    check("t6_press_at", 64'(press_at[0]), 64'(b + 6));
    // random bursts, occasional reset, checked every cycle by the model
    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      key_n = NK'($urandom);
      tick($urandom_range(1, 20));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
